// File: rtl/pong_pkg.sv
// Shared encodings and widths for the pong game sequencer and its helpers.
package pong_pkg;

    localparam int SCORE_W = 4;
    localparam int TIMER_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SERVE    = 3'd1,
        ST_PLAY     = 3'd2,
        ST_POINT    = 3'd3,
        ST_GAMEOVER = 3'd4
    } state_t;

    localparam logic DIR_TO_P2 = 1'b0;
    localparam logic DIR_TO_P1 = 1'b1;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for a raw button/switch, with an optional one-cycle rising-edge pulse.
module btn_sync_edge #(
    parameter bit EDGE_EN = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_s,
    output logic btn_rise
);

    logic [2:0] sync_q;
    logic [2:0] sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], btn_raw};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    // Third stage only serves as the "previous" sample for edge detection.
    assign btn_s    = sync_q[1];
    assign btn_rise = EDGE_EN ? (sync_q[1] & ~sync_q[2]) : 1'b0;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: serve/play/point/game-over flow, scores and frame-counted delays.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned POINT_FRAMES = 90,
    parameter int unsigned WIN_SCORE    = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               btn_start,
    input  logic               sw_pause,
    input  logic               miss_left,
    input  logic               miss_right,
    output logic               ball_en,
    output logic               ball_rst,
    output logic               paddle_en,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] score_p1,
    output logic [SCORE_W-1:0] score_p2,
    output logic               game_over,
    output logic               winner,
    output logic [2:0]         state_o
);

    localparam logic [TIMER_W-1:0] SERVE_LOAD = TIMER_W'(SERVE_FRAMES);
    localparam logic [TIMER_W-1:0] POINT_LOAD = TIMER_W'(POINT_FRAMES);
    localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

    logic start_p;
    logic pause_s;
    logic start_lvl_unused;
    logic pause_rise_unused;

    btn_sync_edge #(.EDGE_EN(1'b1)) u_start_sync (
        .clk      (clk),
        .reset    (reset),
        .btn_raw  (btn_start),
        .btn_s    (start_lvl_unused),
        .btn_rise (start_p)
    );

    btn_sync_edge #(.EDGE_EN(1'b0)) u_pause_sync (
        .clk      (clk),
        .reset    (reset),
        .btn_raw  (sw_pause),
        .btn_s    (pause_s),
        .btn_rise (pause_rise_unused)
    );

    state_t               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [SCORE_W-1:0]   score_p1_q, score_p1_d;
    logic [SCORE_W-1:0]   score_p2_q, score_p2_d;
    logic                 serve_dir_q, serve_dir_d;
    logic                 winner_q, winner_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            score_p1_q  <= '0;
            score_p2_q  <= '0;
            serve_dir_q <= DIR_TO_P2;
            winner_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            score_p1_q  <= score_p1_d;
            score_p2_q  <= score_p2_d;
            serve_dir_q <= serve_dir_d;
            winner_q    <= winner_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        score_p1_d  = score_p1_q;
        score_p2_d  = score_p2_q;
        serve_dir_d = serve_dir_q;
        winner_d    = winner_q;

        case (state_q)
            ST_IDLE, ST_GAMEOVER: begin
                if (start_p) begin
                    state_d     = ST_SERVE;
                    score_p1_d  = '0;
                    score_p2_d  = '0;
                    serve_dir_d = DIR_TO_P2;
                    timer_d     = SERVE_LOAD;
                end
            end
            ST_SERVE: begin
                if (frame_tick) begin
                    timer_d = timer_q - TIMER_W'(1);
                    if (timer_q == TIMER_W'(1)) begin
                        state_d = ST_PLAY;
                    end
                end
            end
            ST_PLAY: begin
                // A simultaneous double miss still ends the rally but awards nobody.
                if (miss_left || miss_right) begin
                    state_d = ST_POINT;
                    timer_d = POINT_LOAD;
                    if (miss_left && !miss_right) begin
                        score_p2_d  = score_p2_q + SCORE_W'(1);
                        serve_dir_d = DIR_TO_P1;
                    end else if (miss_right && !miss_left) begin
                        score_p1_d  = score_p1_q + SCORE_W'(1);
                        serve_dir_d = DIR_TO_P2;
                    end
                end
            end
            ST_POINT: begin
                if (frame_tick && !pause_s) begin
                    timer_d = timer_q - TIMER_W'(1);
                    if (timer_q == TIMER_W'(1)) begin
                        if (score_p1_q == WIN_VAL) begin
                            state_d  = ST_GAMEOVER;
                            winner_d = 1'b0;
                        end else if (score_p2_q == WIN_VAL) begin
                            state_d  = ST_GAMEOVER;
                            winner_d = 1'b1;
                        end else begin
                            state_d = ST_SERVE;
                            timer_d = SERVE_LOAD;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        ball_rst  = 1'b0;
        ball_en   = 1'b0;
        paddle_en = 1'b0;
        game_over = 1'b0;
        case (state_q)
            ST_IDLE:     ball_rst = 1'b1;
            ST_SERVE: begin
                ball_rst  = 1'b1;
                paddle_en = 1'b1;
            end
            ST_PLAY: begin
                ball_en   = !pause_s;
                paddle_en = !pause_s;
            end
            ST_GAMEOVER: game_over = 1'b1;
            default: begin
                ball_rst = 1'b0;
            end
        endcase
    end

    assign state_o   = state_q;
    assign score_p1  = score_p1_q;
    assign score_p2  = score_p2_q;
    assign serve_dir = serve_dir_q;
    assign winner    = winner_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl with short serve/point delays and a low winning score.
module tb_pong_game_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       btn_start = 1'b0;
    logic       sw_pause = 1'b0;
    logic       miss_left = 1'b0;
    logic       miss_right = 1'b0;
    logic       ball_en, ball_rst, paddle_en, serve_dir, game_over, winner;
    logic [3:0] score_p1, score_p2;
    logic [2:0] state_o;

    int checks = 0;
    int errors = 0;

    // {state, ball_rst, ball_en, paddle_en, game_over}
    logic [6:0] ctrl_obs;
    // {score_p1, score_p2, serve_dir, winner}
    logic [9:0] score_obs;
    assign ctrl_obs  = {state_o, ball_rst, ball_en, paddle_en, game_over};
    assign score_obs = {score_p1, score_p2, serve_dir, winner};

    localparam logic [6:0] C_IDLE   = {3'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic [6:0] C_SERVE  = {3'd1, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam logic [6:0] C_PLAY   = {3'd2, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam logic [6:0] C_PLAYPS = {3'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [6:0] C_POINT  = {3'd3, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [6:0] C_OVER   = {3'd4, 1'b0, 1'b0, 1'b0, 1'b1};

    pong_game_ctrl #(
        .SERVE_FRAMES (3),
        .POINT_FRAMES (2),
        .WIN_SCORE    (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .btn_start  (btn_start),
        .sw_pause   (sw_pause),
        .miss_left  (miss_left),
        .miss_right (miss_right),
        .ball_en    (ball_en),
        .ball_rst   (ball_rst),
        .paddle_en  (paddle_en),
        .serve_dir  (serve_dir),
        .score_p1   (score_p1),
        .score_p2   (score_p2),
        .game_over  (game_over),
        .winner     (winner),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    // One frame period: tick is high across exactly one rising edge, ending on a negedge.
    task automatic pulse_tick(input int n);
        for (int i = 0; i < n; i++) begin
            repeat (19) @(negedge clk);
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
        end
    endtask

    task automatic press_start();
        btn_start = 1'b1;
        repeat (5) @(negedge clk);
        btn_start = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic one_miss(input logic l, input logic r);
        miss_left  = l;
        miss_right = r;
        @(negedge clk);
        miss_left  = 1'b0;
        miss_right = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (ctrl_obs !== C_IDLE) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %h expected %h", ctrl_obs, C_IDLE);
        end
        checks++;
        if (score_obs !== 10'd0) begin
            errors++;
            $display("[TB] FAIL reset_scores: got %h expected %h", score_obs, 10'd0);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_start();
        btn_start = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (ctrl_obs !== C_IDLE) begin
            errors++;
            $display("[TB] FAIL start_too_early: got %h expected %h", ctrl_obs, C_IDLE);
        end
        @(negedge clk);
        checks++;
        if (ctrl_obs !== C_SERVE) begin
            errors++;
            $display("[TB] FAIL start_serve: got %h expected %h", ctrl_obs, C_SERVE);
        end
        repeat (2) @(negedge clk);
        btn_start = 1'b0;
        repeat (4) @(negedge clk);
        pulse_tick(2);
        checks++;
        if (ctrl_obs !== C_SERVE) begin
            errors++;
            $display("[TB] FAIL serve_dwell: got %h expected %h", ctrl_obs, C_SERVE);
        end
        pulse_tick(1);
        checks++;
        if (ctrl_obs !== C_PLAY) begin
            errors++;
            $display("[TB] FAIL serve_to_play: got %h expected %h", ctrl_obs, C_PLAY);
        end
    endtask

    task automatic test_miss_left();
        one_miss(1'b1, 1'b0);
        checks++;
        if (ctrl_obs !== C_POINT) begin
            errors++;
            $display("[TB] FAIL missl_point: got %h expected %h", ctrl_obs, C_POINT);
        end
        checks++;
        if (score_obs !== {4'd0, 4'd1, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL missl_score: got %h expected %h", score_obs, {4'd0, 4'd1, 1'b1, 1'b0});
        end
        pulse_tick(1);
        checks++;
        if (ctrl_obs !== C_POINT) begin
            errors++;
            $display("[TB] FAIL point_dwell: got %h expected %h", ctrl_obs, C_POINT);
        end
        pulse_tick(1);
        checks++;
        if (ctrl_obs !== C_SERVE) begin
            errors++;
            $display("[TB] FAIL point_to_serve: got %h expected %h", ctrl_obs, C_SERVE);
        end
        pulse_tick(3);
        checks++;
        if (ctrl_obs !== C_PLAY) begin
            errors++;
            $display("[TB] FAIL reserve_play: got %h expected %h", ctrl_obs, C_PLAY);
        end
    endtask

    task automatic test_both_miss();
        one_miss(1'b1, 1'b1);
        checks++;
        if (ctrl_obs !== C_POINT) begin
            errors++;
            $display("[TB] FAIL both_point: got %h expected %h", ctrl_obs, C_POINT);
        end
        checks++;
        if (score_obs !== {4'd0, 4'd1, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL both_score: got %h expected %h", score_obs, {4'd0, 4'd1, 1'b1, 1'b0});
        end
        pulse_tick(2);
        checks++;
        if (ctrl_obs !== C_SERVE) begin
            errors++;
            $display("[TB] FAIL both_to_serve: got %h expected %h", ctrl_obs, C_SERVE);
        end
        pulse_tick(3);
    endtask

    task automatic test_pause();
        sw_pause = 1'b1;
        @(negedge clk);
        checks++;
        if (ctrl_obs !== C_PLAY) begin
            errors++;
            $display("[TB] FAIL pause_latency: got %h expected %h", ctrl_obs, C_PLAY);
        end
        @(negedge clk);
        checks++;
        if (ctrl_obs !== C_PLAYPS) begin
            errors++;
            $display("[TB] FAIL pause_play: got %h expected %h", ctrl_obs, C_PLAYPS);
        end
        pulse_tick(1);
        checks++;
        if (ctrl_obs !== C_PLAYPS) begin
            errors++;
            $display("[TB] FAIL tick_in_play: got %h expected %h", ctrl_obs, C_PLAYPS);
        end
        one_miss(1'b0, 1'b1);
        checks++;
        if (score_obs !== {4'd1, 4'd1, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL missr_paused: got %h expected %h", score_obs, {4'd1, 4'd1, 1'b0, 1'b0});
        end
        pulse_tick(3);
        checks++;
        if (ctrl_obs !== C_POINT) begin
            errors++;
            $display("[TB] FAIL point_paused: got %h expected %h", ctrl_obs, C_POINT);
        end
        sw_pause = 1'b0;
        repeat (3) @(negedge clk);
        pulse_tick(1);
        checks++;
        if (ctrl_obs !== C_POINT) begin
            errors++;
            $display("[TB] FAIL point_resume: got %h expected %h", ctrl_obs, C_POINT);
        end
        pulse_tick(1);
        checks++;
        if (ctrl_obs !== C_SERVE) begin
            errors++;
            $display("[TB] FAIL point_ext_serve: got %h expected %h", ctrl_obs, C_SERVE);
        end
        pulse_tick(3);
    endtask

    task automatic test_win();
        one_miss(1'b0, 1'b1);
        pulse_tick(2);
        checks++;
        if (ctrl_obs !== C_OVER) begin
            errors++;
            $display("[TB] FAIL gameover: got %h expected %h", ctrl_obs, C_OVER);
        end
        checks++;
        if (score_obs !== {4'd2, 4'd1, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL win_scores: got %h expected %h", score_obs, {4'd2, 4'd1, 1'b0, 1'b0});
        end
        pulse_tick(1);
        checks++;
        if ({ctrl_obs, score_obs} !== {C_OVER, 4'd2, 4'd1, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL gameover_hold: got %h expected %h", {ctrl_obs, score_obs}, {C_OVER, 4'd2, 4'd1, 1'b0, 1'b0});
        end
        press_start();
        checks++;
        if ({ctrl_obs, score_obs} !== {C_SERVE, 10'd0}) begin
            errors++;
            $display("[TB] FAIL restart: got %h expected %h", {ctrl_obs, score_obs}, {C_SERVE, 10'd0});
        end
    endtask

    task automatic test_back_to_back();
        pulse_tick(1);
        press_start();
        checks++;
        if (ctrl_obs !== C_SERVE) begin
            errors++;
            $display("[TB] FAIL start_in_serve: got %h expected %h", ctrl_obs, C_SERVE);
        end
        pulse_tick(2);
        checks++;
        if (ctrl_obs !== C_PLAY) begin
            errors++;
            $display("[TB] FAIL no_reload: got %h expected %h", ctrl_obs, C_PLAY);
        end
        press_start();
        checks++;
        if ({ctrl_obs, score_obs} !== {C_PLAY, 10'd0}) begin
            errors++;
            $display("[TB] FAIL start_in_play: got %h expected %h", {ctrl_obs, score_obs}, {C_PLAY, 10'd0});
        end
    endtask

    task automatic test_reset_mid();
        one_miss(1'b1, 1'b0);
        pulse_tick(5);
        checks++;
        if ({ctrl_obs, score_obs} !== {C_PLAY, 4'd0, 4'd1, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL pre_reset: got %h expected %h", {ctrl_obs, score_obs}, {C_PLAY, 4'd0, 4'd1, 1'b1, 1'b0});
        end
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        checks++;
        if ({ctrl_obs, score_obs} !== {C_IDLE, 10'd0}) begin
            errors++;
            $display("[TB] FAIL async_reset: got %h expected %h", {ctrl_obs, score_obs}, {C_IDLE, 10'd0});
        end
        @(negedge clk);
        reset = 1'b0;
        pulse_tick(1);
        checks++;
        if (ctrl_obs !== C_IDLE) begin
            errors++;
            $display("[TB] FAIL idle_wait: got %h expected %h", ctrl_obs, C_IDLE);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_miss_left();
        test_both_miss();
        test_pause();
        test_win();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Top-level game sequencer for the pong datapath (ball mover, paddle movers, border/paddle/ball renderer, vga_sync).
- Runs IDLE -> SERVE -> PLAY -> POINT -> ... -> GAMEOVER, keeps both scores and enforces serve and point delays.
- Drives enable/recentre controls into the ball and paddle logic. Advances only on the per-frame animate tick (the y==480, x==0 pulse), except for misses and the start button.

Parameters:
SERVE_FRAMES, 60, frame ticks the ball is held centred before launch (1..255)
POINT_FRAMES, 90, frame ticks the ball is frozen after a miss (1..255)
WIN_SCORE, 7, score that ends the game (1..15)

Ports:
clk  in  1  system clock; all logic in this domain
reset  in  1  asynchronous, active-high; clears all state immediately
frame_tick  in  1  one-cycle pulse per frame (animate), synchronous to clk
btn_start  in  1  raw start button, asynchronous
sw_pause  in  1  raw pause switch, asynchronous, level
miss_left  in  1  level from ball logic: ball passed P1 paddle (P2 scores)
miss_right  in  1  level from ball logic: ball passed P2 paddle (P1 scores)
ball_en  out  1  ball may move this frame
ball_rst  out  1  hold ball at screen centre
paddle_en  out  1  paddles accept button movement
serve_dir  out  1  launch direction; 0 = toward P2 (right), 1 = toward P1 (left)
score_p1  out  4  P1 score
score_p2  out  4  P2 score
game_over  out  1  high in GAMEOVER
winner  out  1  0 = P1, 1 = P2; valid only while game_over
state_o  out  3  current state code, for debug/display

Behaviour:
- Reset values: state IDLE, scores 0, serve_dir 0, winner 0, timer 0, synchronizers 0. Resulting outputs: ball_rst=1, ball_en=0, paddle_en=0, game_over=0.
- btn_start and sw_pause: each passes a 2-FF synchronizer. Start uses a rising-edge pulse start_p, one cycle wide and 3 cycles after the raw edge. The pause level is used as-is after synchronization (pause_s).
- Outputs are Moore, decoded only from registered state; scores, serve_dir and winner are registers.
- Per-state outputs:
  - IDLE: ball_rst=1, ball_en=0, paddle_en=0.
  - SERVE: ball_rst=1, ball_en=0, paddle_en=1.
  - PLAY: ball_rst=0, ball_en=!pause_s, paddle_en=!pause_s.
  - POINT: ball_rst=0, ball_en=0, paddle_en=0.
  - GAMEOVER: ball_rst=0, ball_en=0, paddle_en=0, game_over=1.
- 8-bit frame timer. On load it takes the delay value. On each frame_tick it decrements. When a frame_tick arrives with timer==1, the state exits. The dwell is therefore exactly N frame ticks after entry.
- IDLE: start_p -> SERVE; clear scores, serve_dir=0, load SERVE_FRAMES.
- SERVE: timer expiry -> PLAY. Misses ignored. start_p ignored.
- PLAY:
  - miss_left alone -> score_p2+1, serve_dir=1, load POINT_FRAMES, -> POINT.
  - miss_right alone -> score_p1+1, serve_dir=0, load POINT_FRAMES, -> POINT.
  - Both in the same cycle -> no score change, serve_dir unchanged, -> POINT.
  - Misses are acted on even while paused.
  - frame_tick has no effect in PLAY.
- POINT:
  - Timer holds while pause_s=1.
  - On expiry, if score_p1==WIN_SCORE -> GAMEOVER with winner=0.
  - Else if score_p2==WIN_SCORE -> GAMEOVER with winner=1.
  - Else -> SERVE, load SERVE_FRAMES.
  - Misses are ignored.
- GAMEOVER: scores and winner held. start_p -> SERVE; clear scores, serve_dir=0, load SERVE_FRAMES.
- Only one score increments per point, so the two scores cannot reach WIN_SCORE together. Scores never exceed WIN_SCORE; no wrap logic is required.
- start_p in SERVE, PLAY or POINT is ignored, with no restart.
- A frame_tick coinciding with a state change is consumed by the state being exited.
- Reset asserted mid-game: outputs take reset values asynchronously. After deassertion the block waits in IDLE for start_p.
- Unused state codes go to IDLE on the next clk edge.

Decomposition:
- pong_pkg: state encoding (IDLE=0, SERVE=1, PLAY=2, POINT=3, GAMEOVER=4), serve_dir constants, score width (4) and timer width (8).
- Sub-module btn_sync_edge: 2-FF synchronizer with optional rising-edge output. Instantiated twice: start (edge) and pause (level). It is reusable for the paddle buttons btnU/btnD/btnL/btnR.

Test Plan:
Bench parameters: SERVE_FRAMES=3, POINT_FRAMES=2, WIN_SCORE=2; frame_tick every 20 clk.
1. Release reset, pulse btn_start for 5 clk -> SERVE three cycles after the raw edge; ball_rst=1, paddle_en=1; PLAY entered on the 3rd frame_tick with ball_en=1, ball_rst=0.
2. In PLAY, assert miss_left one cycle -> next cycle state POINT, score_p2=1, serve_dir=1; after 2 frame_ticks -> SERVE.
3. miss_left and miss_right in the same cycle -> POINT with scores unchanged and serve_dir unchanged.
4. Drive score_p1 to 2 -> after POINT expiry game_over=1, winner=0, scores 2/x held; btn_start -> SERVE, scores 0/0, serve_dir=0.
5. sw_pause=1 during PLAY -> ball_en=0, paddle_en=0 after sync latency. sw_pause=1 during POINT -> POINT extends by the paused frames.
6. Assert reset mid-PLAY between clk edges -> outputs return to reset values before the next edge; btn_start pressed during SERVE causes no restart.
